// File: rtl/m72_pkg.sv
// Shared M72/M84 constants: SDRAM region map and common types.
// Imported by the sound-side memory blocks.
package m72_pkg;

    localparam int SDRAM_AW = 25;

    // Sample ROM region inside SDRAM (byte addresses).
    localparam logic [SDRAM_AW-1:0] SAMPLE_ROM_BASE = 25'h0000000;
    localparam logic [SDRAM_AW-1:0] SAMPLE_ROM_SIZE = 25'h0010000;

    typedef enum logic {
        IDLE,
        WAIT
    } fetch_state_e;

endpackage

// File: rtl/m84_sample_fetch.sv
// M84 sample port: address register, ROM prefetch, DAC byte to audio.
// One outstanding SDRAM request; stale results are dropped.
module m84_sample_fetch
    import m72_pkg::*;
#(
    parameter int                ROM_AW   = 25,
    parameter logic [ROM_AW-1:0] ROM_BASE = ROM_AW'(SAMPLE_ROM_BASE)
) (
    input  logic              CLK_32M,
    input  logic              reset,
    input  logic [15:0]       sample_addr,
    input  logic [1:0]        sample_addr_wr,
    input  logic              sample_inc,
    input  logic [7:0]        sample_out,
    output logic [7:0]        sample_in,
    output logic              sample_valid,
    output logic              rom_req,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    input  logic              rom_ack,
    output logic [15:0]       audio_out
);

    fetch_state_e      state_q, state_d;
    logic [15:0]       addr_q, addr_d;
    logic              pending_q, pending_d;
    logic              boot_q;
    logic              req_q, req_d;
    logic [ROM_AW-1:0] raddr_q, raddr_d;
    logic [7:0]        sin_q, sin_d;
    logic              valid_q, valid_d;
    logic [15:0]       audio_q, audio_d;
    logic              addr_chg;

    assign addr_chg = (|sample_addr_wr) | sample_inc;

    // Address register: writes take priority over the post-increment.
    always_comb begin
        addr_d  = addr_q;
        audio_d = audio_q;
        if (|sample_addr_wr) begin
            if (sample_addr_wr[0]) addr_d[7:0]  = sample_addr[7:0];
            if (sample_addr_wr[1]) addr_d[15:8] = sample_addr[15:8];
        end else if (sample_inc) begin
            addr_d = addr_q + 16'd1;
        end
        if (sample_inc) audio_d = {sample_out ^ 8'h80, 8'h00};
    end

    // Fetch FSM next state; an address move always invalidates and re-queues.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q | boot_q;
        req_d     = req_q;
        raddr_d   = raddr_q;
        sin_d     = sin_q;
        valid_d   = valid_q;
        unique case (state_q)
            IDLE: begin
                if (pending_q) begin
                    raddr_d   = ROM_BASE + ROM_AW'(addr_q);
                    req_d     = 1'b1;
                    pending_d = 1'b0;
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                if (rom_ack) begin
                    req_d   = 1'b0;
                    state_d = IDLE;
                    if (!pending_q && !addr_chg) begin
                        sin_d   = rom_data;
                        valid_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (addr_chg) begin
            pending_d = 1'b1;
            valid_d   = 1'b0;
        end
    end

    // State registers; boot_q queues the fetch of address 0 after reset.
    always_ff @(posedge CLK_32M) begin
        if (reset) begin
            state_q   <= IDLE;
            addr_q    <= 16'h0000;
            pending_q <= 1'b0;
            boot_q    <= 1'b1;
            req_q     <= 1'b0;
            raddr_q   <= ROM_BASE;
            sin_q     <= 8'h00;
            valid_q   <= 1'b0;
            audio_q   <= 16'h0000;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            pending_q <= pending_d;
            boot_q    <= 1'b0;
            req_q     <= req_d;
            raddr_q   <= raddr_d;
            sin_q     <= sin_d;
            valid_q   <= valid_d;
            audio_q   <= audio_d;
        end
    end

    assign sample_in    = sin_q;
    assign sample_valid = valid_q;
    assign rom_req      = req_q;
    assign rom_addr     = raddr_q;
    assign audio_out    = audio_q;

endmodule

// File: tb/tb_m84_sample_fetch.sv
// Directed bench for m84_sample_fetch with a delayed-ack ROM responder.
// Each task drives one scenario and checks hand-computed values.
module tb_m84_sample_fetch;

    localparam int          AW   = 25;
    localparam logic [24:0] BASE = 25'h0100000;

    logic          CLK_32M = 1'b0;
    logic          reset = 1'b1;
    logic [15:0]   sample_addr = '0;
    logic [1:0]    sample_addr_wr = '0;
    logic          sample_inc = 1'b0;
    logic [7:0]    sample_out = '0;
    logic [7:0]    sample_in;
    logic          sample_valid;
    logic          rom_req;
    logic [AW-1:0] rom_addr;
    logic [7:0]    rom_data = '0;
    logic          rom_ack = 1'b0;
    logic [15:0]   audio_out;

    int errors = 0;
    int checks = 0;

    int          ack_dly = 4;
    bit          manual = 1'b0;
    bit          busy = 1'b0;
    int          cnt = 0;
    logic [24:0] lat_addr = '0;
    logic [24:0] log_q[$];

    m84_sample_fetch #(.ROM_AW(AW), .ROM_BASE(BASE)) dut (
        .CLK_32M       (CLK_32M),
        .reset         (reset),
        .sample_addr   (sample_addr),
        .sample_addr_wr(sample_addr_wr),
        .sample_inc    (sample_inc),
        .sample_out    (sample_out),
        .sample_in     (sample_in),
        .sample_valid  (sample_valid),
        .rom_req       (rom_req),
        .rom_addr      (rom_addr),
        .rom_data      (rom_data),
        .rom_ack       (rom_ack),
        .audio_out     (audio_out)
    );

    always #15 CLK_32M = ~CLK_32M;

    // ROM contents: byte = lo ^ hi ^ 5A of the region-relative address.
    function automatic logic [7:0] rom_byte(input logic [24:0] ra);
        logic [15:0] a;
        a = 16'(ra - BASE);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    // SDRAM model: latch a request, answer ack_dly cycles later.
    always @(negedge CLK_32M) begin
        if (!manual) begin
            rom_ack = 1'b0;
            if (busy) begin
                if (cnt == 0) begin
                    rom_ack  = 1'b1;
                    rom_data = rom_byte(lat_addr);
                    busy     = 1'b0;
                end else begin
                    cnt = cnt - 1;
                end
            end else if (rom_req) begin
                busy     = 1'b1;
                lat_addr = rom_addr;
                cnt      = ack_dly - 1;
                log_q.push_back(rom_addr);
            end
        end
    end

    task automatic pulse(input logic [1:0] wr, input logic [15:0] a,
                         input logic inc, input logic [7:0] so);
        @(negedge CLK_32M); #1;
        sample_addr_wr = wr;
        sample_addr    = a;
        sample_inc     = inc;
        sample_out     = so;
        @(negedge CLK_32M); #1;
        sample_addr_wr = '0;
        sample_inc     = 1'b0;
    endtask

    task automatic wait_valid(input string nm);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge CLK_32M); #1;
            if (sample_valid) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s timeout: sample_valid=%0b want 1", nm, sample_valid);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge CLK_32M);
        #1;
        checks++;
        if (rom_req !== 1'b0 || sample_valid !== 1'b0 || sample_in !== 8'h00 ||
            audio_out !== 16'h0000 || rom_addr !== BASE) begin
            errors++;
            $display("FAIL reset_state: req=%b val=%b in=%h aud=%h ra=%h",
                     rom_req, sample_valid, sample_in, audio_out, rom_addr);
        end
        reset = 1'b0;
    endtask

    task automatic test_boot_fetch();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK_32M); #1;
            if (rom_ack) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok || rom_addr !== BASE || sample_valid !== 1'b0) begin
            errors++;
            $display("FAIL boot_req: ack=%b ra=%h val=%b want ra=%h val=0",
                     ok, rom_addr, sample_valid, BASE);
        end
        @(negedge CLK_32M); #1;
        checks++;
        if (sample_valid !== 1'b1 || sample_in !== 8'h5A || rom_req !== 1'b0) begin
            errors++;
            $display("FAIL boot_data: val=%b in=%h req=%b want 1 5a 0",
                     sample_valid, sample_in, rom_req);
        end
    endtask

    task automatic test_addr_write();
        bit saw_stale;
        bit ok;
        log_q.delete();
        pulse(2'b01, 16'h0034, 1'b0, 8'h00);
        checks++;
        if (sample_valid !== 1'b0) begin
            errors++;
            $display("FAIL wr_invalidate: val=%b want 0", sample_valid);
        end
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (busy) begin
                ok = 1'b1;
                break;
            end
            @(negedge CLK_32M); #1;
        end
        pulse(2'b10, 16'h1200, 1'b0, 8'h00);
        saw_stale = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge CLK_32M); #1;
            if (sample_in == 8'h6E) saw_stale = 1'b1;
            if (sample_valid) break;
        end
        checks++;
        if (!ok || log_q.size() != 2 || saw_stale) begin
            errors++;
            $display("FAIL wr_fetches: n=%0d stale=%b want n=2 stale=0",
                     log_q.size(), saw_stale);
        end else begin
            checks++;
            if (log_q[0] !== BASE + 25'h0034 || log_q[1] !== BASE + 25'h1234) begin
                errors++;
                $display("FAIL wr_addrs: %h %h want %h %h", log_q[0], log_q[1],
                         BASE + 25'h0034, BASE + 25'h1234);
            end
        end
        checks++;
        if (sample_valid !== 1'b1 || sample_in !== 8'h7C) begin
            errors++;
            $display("FAIL wr_data: val=%b in=%h want 1 7c", sample_valid, sample_in);
        end
    endtask

    task automatic test_wrap();
        pulse(2'b11, 16'hFFFF, 1'b0, 8'h00);
        wait_valid("wrap_setup");
        checks++;
        if (log_q[$] !== BASE + 25'hFFFF || sample_in !== 8'h5A) begin
            errors++;
            $display("FAIL wrap_setup: ra=%h in=%h want %h 5a",
                     log_q[$], sample_in, BASE + 25'hFFFF);
        end
        pulse(2'b00, 16'h0000, 1'b1, 8'h00);
        checks++;
        if (audio_out !== 16'h8000 || sample_valid !== 1'b0) begin
            errors++;
            $display("FAIL wrap_inc: aud=%h val=%b want 8000 0", audio_out, sample_valid);
        end
        wait_valid("wrap_fetch");
        checks++;
        if (log_q[$] !== BASE || sample_in !== 8'h5A) begin
            errors++;
            $display("FAIL wrap_addr: ra=%h in=%h want %h 5a", log_q[$], sample_in, BASE);
        end
    endtask

    task automatic test_back_to_back();
        pulse(2'b00, 16'h0000, 1'b1, 8'hFF);
        checks++;
        if (audio_out !== 16'h7F00) begin
            errors++;
            $display("FAIL audio_ff: got %h want 7f00", audio_out);
        end
        pulse(2'b00, 16'h0000, 1'b1, 8'h80);
        checks++;
        if (audio_out !== 16'h0000) begin
            errors++;
            $display("FAIL audio_80: got %h want 0000", audio_out);
        end
        wait_valid("b2b_fetch");
        checks++;
        if (log_q[$] !== BASE + 25'h2 || sample_in !== 8'h58) begin
            errors++;
            $display("FAIL b2b_addr: ra=%h in=%h want %h 58",
                     log_q[$], sample_in, BASE + 25'h2);
        end
    endtask

    task automatic test_inc_and_write();
        pulse(2'b11, 16'h0200, 1'b1, 8'h12);
        checks++;
        if (audio_out !== 16'h9200) begin
            errors++;
            $display("FAIL incwr_audio: got %h want 9200", audio_out);
        end
        wait_valid("incwr_fetch");
        checks++;
        if (log_q[$] !== BASE + 25'h0200 || sample_in !== 8'h58) begin
            errors++;
            $display("FAIL incwr_addr: ra=%h in=%h want %h 58",
                     log_q[$], sample_in, BASE + 25'h0200);
        end
    endtask

    task automatic test_reset_mid_fetch();
        bit ok;
        ack_dly = 10;
        pulse(2'b11, 16'h0010, 1'b0, 8'h00);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (busy) begin
                ok = 1'b1;
                break;
            end
            @(negedge CLK_32M); #1;
        end
        manual = 1'b1;
        busy   = 1'b0;
        @(negedge CLK_32M); #1;
        reset = 1'b1;
        @(negedge CLK_32M); #1;
        reset = 1'b0;
        checks++;
        if (!ok || rom_req !== 1'b0 || rom_addr !== BASE || audio_out !== 16'h0000) begin
            errors++;
            $display("FAIL midrst_state: busy=%b req=%b ra=%h aud=%h",
                     ok, rom_req, rom_addr, audio_out);
        end
        @(negedge CLK_32M); #1;
        rom_ack  = 1'b1;
        rom_data = 8'hEE;
        @(negedge CLK_32M); #1;
        rom_ack  = 1'b0;
        checks++;
        if (sample_valid !== 1'b0 || sample_in !== 8'h00 ||
            rom_req !== 1'b1 || rom_addr !== BASE) begin
            errors++;
            $display("FAIL midrst_late_ack: val=%b in=%h req=%b ra=%h want 0 00 1 %h",
                     sample_valid, sample_in, rom_req, rom_addr, BASE);
        end
        ack_dly = 3;
        manual  = 1'b0;
        wait_valid("midrst_fetch");
        checks++;
        if (sample_in !== 8'h5A || log_q[$] !== BASE) begin
            errors++;
            $display("FAIL midrst_data: in=%h ra=%h want 5a %h", sample_in, log_q[$], BASE);
        end
    endtask

    initial begin
        test_reset();
        test_boot_fetch();
        test_addr_write();
        test_wrap();
        test_back_to_back();
        test_inc_and_write();
        test_reset_mid_fetch();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
